// File: rtl/score_bcd_converter_if.sv
// Handshake bundle between the score counter (master) and the BCD converter (slave).
// Carries the request, the binary value and the registered BCD result.
interface score_bcd_converter_if #(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
);
  logic                start;
  logic [BIN_W-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [NDIG*4-1:0]   digits_out;
  logic                overflow;

  modport master (
    output start, bin_in,
    input  busy, done, digits_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, digits_out, overflow
  );
endinterface

// File: rtl/score_bcd_converter.sv
// Binary-to-packed-BCD converter for the HUD score digits: iterative double dabble,
// one input bit per clock, saturating to all nines when the value needs more than NDIG digits.
module score_bcd_converter #(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  score_bcd_converter_if.slave bus
);
  localparam int SW = (NDIG + 1) * 4;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shreg_q, shreg_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NDIG*4-1:0]   digits_q, digits_d;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i <= NDIG; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      else                             adj[4*i +: 4] = scratch_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (bus.start) begin
          shreg_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = CW'(BIN_W);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          // Any nonzero digit above NDIG means the value does not fit: saturate.
          if (scratch_d[SW-1:NDIG*4] != '0) begin
            ovf_d    = 1'b1;
            digits_d = {NDIG{4'h9}};
          end else begin
            ovf_d    = 1'b0;
            digits_d = scratch_d[NDIG*4-1:0];
          end
        end
      end
      S_DONE: begin
        // The DONE exit edge doubles as an accept edge, so back-to-back
        // conversions complete every BIN_W+1 cycles.
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (bus.start) begin
          shreg_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = CW'(BIN_W);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.digits_out = digits_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed and random checks of score_bcd_converter against a decimal-arithmetic model.
module tb_score_bcd_converter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] prev_d = '0;
  logic        prev_o = 1'b0;

  score_bcd_converter_if #(.BIN_W(14), .NDIG(4)) bus ();
  score_bcd_converter #(.BIN_W(14), .NDIG(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  // {overflow, digits}: decimal digits of v, or all nines when v needs a fifth digit
  function automatic logic [16:0] ref_model(input int v);
    logic [16:0] r;
    int p;
    r = '0;
    if (v >= 10000) return {1'b1, 16'h9999};
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input int v, input string tag);
    logic [16:0] e;
    int n, busy_n;
    bit held;
    e = ref_model(v);
    @(negedge Clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'(v);
    @(negedge Clk);
    bus.start = 1'b0;
    n = 0; busy_n = 0; held = 1'b1;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_n++;
      if (bus.digits_out !== prev_d || bus.overflow !== prev_o) held = 1'b0;
      bus.bin_in = 14'($urandom);
      bus.start  = 1'($urandom_range(0, 1));
      @(negedge Clk);
      n++;
    end
    bus.start = 1'b0;
    if (bus.busy) busy_n++;
    chk({tag, "_latency"}, n, 14);
    chk({tag, "_digits"}, bus.digits_out, e[15:0]);
    chk({tag, "_ovf"}, bus.overflow, e[16]);
    chk({tag, "_held"}, held, 1);
    @(negedge Clk);
    chk({tag, "_done_1cyc"}, bus.done, 0);
    chk({tag, "_busy_total"}, busy_n + (bus.busy ? 1 : 0), 15);
    prev_d = e[15:0];
    prev_o = e[16];
  endtask

  initial begin
    logic [16:0] q[$];
    logic [16:0] e;
    int cyc, last, got, n_done;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge Clk);
    chk("rst_digits", bus.digits_out, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    convert(0, "zero");
    convert(1234, "v1234");
    convert(9999, "v9999");
    convert(7, "v7");
    convert(10000, "v10000");
    convert(16383, "v16383");
    convert(42, "v42");

    // start held high: a value is taken at every edge that follows an idle or done cycle
    @(negedge Clk);
    bus.start = 1'b1;
    last = -1; got = 0; cyc = 0;
    q.delete();
    bus.bin_in = 14'($urandom);
    q.push_back(ref_model(int'(bus.bin_in)));
    while (got < 4 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (bus.done) begin
        e = q.pop_front();
        chk("b2b_digits", bus.digits_out, e[15:0]);
        chk("b2b_ovf", bus.overflow, e[16]);
        if (last >= 0) chk("b2b_spacing", cyc - last, 15);
        last = cyc;
        got++;
        prev_d = e[15:0];
        prev_o = e[16];
      end
      bus.bin_in = 14'($urandom);
      if (!bus.busy || bus.done) q.push_back(ref_model(int'(bus.bin_in)));
    end
    bus.start = 1'b0;
    chk("b2b_count", got, 4);
    repeat (2) @(negedge Clk);

    convert(1234, "pre_rst");
    @(negedge Clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd777;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_digits", bus.digits_out, 0);
    chk("midrst_ovf", bus.overflow, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge Clk);
      if (bus.done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    prev_d = '0;
    prev_o = 1'b0;
    convert(305, "v305");

    for (int i = 0; i < 120; i++) convert($urandom_range(0, 16383), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
